// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART: register map, CON bit layout,
// FSM state encoding and the baud divider helper.
package uart_mmio_pkg;

  localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;

  localparam int CON_TX_BUSY   = 0;
  localparam int CON_RX_VALID  = 1;
  localparam int CON_FRAME_ERR = 2;
  localparam int CON_OVERRUN   = 3;
  localparam int CON_IRQ_EN    = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

  // 16x oversampling divider, clamped so a slow clock still gives a tick.
  function automatic int calc_baud_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * 16);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running 16x baud tick: one-cycle pulse every DIV sysclk cycles.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic sysclk,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Counter wraps to 0 after LAST; it is never restarted by the FSMs.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)            cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON registers, 16x oversampled receiver,
// transmitter and a registered receive interrupt.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 9600
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        UART_RX,
  output logic        UART_TX,
  output logic        IRQ
);

  localparam int BAUD_DIV = calc_baud_div(CLK_HZ, BAUD);

  logic tick;

  uart_baud_tick #(.DIV(BAUD_DIV)) u_baud_tick (
    .sysclk (sysclk),
    .reset  (reset),
    .tick   (tick)
  );

  // ---------------- bus side ----------------
  logic wr_q, rd_q;
  logic wr_txd, wr_con, rd_rxd;

  // Edge detectors so a long wr/rd strobe acts only once.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      wr_q <= wr;
      rd_q <= rd;
    end
  end

  assign wr_txd = wr & ~wr_q & (addr == ADDR_TXD);
  assign wr_con = wr & ~wr_q & (addr == ADDR_CON);
  assign rd_rxd = rd & ~rd_q & (addr == ADDR_RXD);

  // Upper write-data bits are not part of any register.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  // ---------------- receiver ----------------
  logic rx_s1, rx_s2, rx_prev, rx_fall;

  // Two-flop synchroniser plus one more stage for falling-edge detection.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= UART_RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;

  uart_state_e rx_state, rx_state_n;
  logic [3:0]  rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_load, rx_ferr_set;

  // RX state and counters.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // RX next state: mid-bit sampling (8 ticks into start, then every 16).
  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_load     = 1'b0;
    rx_ferr_set = 1'b0;
    unique case (rx_state)
      ST_IDLE: begin
        if (rx_fall) begin
          rx_state_n = ST_START;
          rx_cnt_n   = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (rx_cnt == 4'd7) begin
            rx_cnt_n   = '0;
            rx_bit_n   = '0;
            // A line already high again was a glitch, not a start bit.
            rx_state_n = rx_s2 ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt_n = rx_cnt + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          rx_cnt_n = rx_cnt + 4'd1;
          if (rx_cnt == 4'd15) begin
            rx_shift_n = {rx_s2, rx_shift[7:1]};
            rx_bit_n   = rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state_n = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          rx_cnt_n = rx_cnt + 4'd1;
          if (rx_cnt == 4'd15) begin
            rx_state_n = ST_IDLE;
            if (rx_s2) rx_load     = 1'b1;
            else       rx_ferr_set = 1'b1;
          end
        end
      end
      default: rx_state_n = ST_IDLE;
    endcase
  end

  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, irq_en;

  // Status flags; a byte completing in the read cycle keeps rx_valid set.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      irq_en    <= 1'b0;
    end else begin
      if (rx_load)     rx_data  <= rx_shift;
      if (rx_load)     rx_valid <= 1'b1;
      else if (rd_rxd) rx_valid <= 1'b0;
      if (rx_load && rx_valid && !rd_rxd) overrun <= 1'b1;
      else if (wr_con && wdata[3])        overrun <= 1'b0;
      if (rx_ferr_set)                    frame_err <= 1'b1;
      else if (wr_con && wdata[2])        frame_err <= 1'b0;
      if (wr_con) irq_en <= wdata[4];
    end
  end

  // Interrupt is registered, so it trails the flags by one cycle.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) IRQ <= 1'b0;
    else        IRQ <= irq_en & rx_valid;
  end

  // ---------------- transmitter ----------------
  uart_state_e tx_state, tx_state_n;
  logic [3:0]  tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_line, tx_line_n, tx_busy;

  assign tx_busy = (tx_state != ST_IDLE);
  assign UART_TX = tx_line;

  // TX state, counters and the registered line driver.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
    end
  end

  // TX next state: each bit held for 16 ticks; writes outside IDLE are dropped.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = tx_line;
    unique case (tx_state)
      ST_IDLE: begin
        tx_line_n = 1'b1;
        if (wr_txd) begin
          tx_shift_n = wdata[7:0];
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_line_n  = 1'b0;
          tx_state_n = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          tx_cnt_n = tx_cnt + 4'd1;
          if (tx_cnt == 4'd15) begin
            tx_state_n = ST_DATA;
            tx_line_n  = tx_shift[0];
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          tx_cnt_n = tx_cnt + 4'd1;
          if (tx_cnt == 4'd15) begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            if (tx_bit == 3'd7) begin
              tx_state_n = ST_STOP;
              tx_line_n  = 1'b1;
            end else begin
              tx_line_n = tx_shift[1];
            end
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          tx_cnt_n = tx_cnt + 4'd1;
          if (tx_cnt == 4'd15) tx_state_n = ST_IDLE;
        end
      end
      default: tx_state_n = ST_IDLE;
    endcase
  end

  // ---------------- read mux ----------------
  logic [31:0] con_word;

  // Read data is zero unless a mapped register is being read.
  always_comb begin
    con_word                = '0;
    con_word[CON_TX_BUSY]   = tx_busy;
    con_word[CON_RX_VALID]  = rx_valid;
    con_word[CON_FRAME_ERR] = frame_err;
    con_word[CON_OVERRUN]   = overrun;
    con_word[CON_IRQ_EN]    = irq_en;
    rdata = '0;
    if (rd) begin
      if (addr == ADDR_RXD)      rdata = {24'b0, rx_data};
      else if (addr == ADDR_CON) rdata = con_word;
    end
  end

endmodule
